// File: rtl/issue_pipe_buf_pkg.sv
// Shared widths and the modulo tag-age compare used by the issue buffer,
// launch select and writeback ordering.
package issue_pipe_buf_pkg;

  localparam int ISSUE_LANES  = 2;
  localparam int ISSUE_TAG_W  = 3;
  localparam int ISSUE_DATA_W = 160;

  // t is younger than k iff (t - k) mod 2^w lies in [1, 2^(w-1) - 1]
  function automatic logic tag_younger(input logic [31:0] t, input logic [31:0] k,
                                       input int unsigned w);
    logic [31:0] mask, d, lim;
    mask = (32'd1 << w) - 32'd1;
    d    = (t - k) & mask;
    lim  = (32'd1 << (w - 1)) - 32'd1;
    return (d != 32'd0) && (d <= lim);
  endfunction

endpackage

// File: rtl/issue_pipe_buf_bundle_slot.sv
// One bundle slot: lane valids, tags and payload, with the kill mask applied
// to the held lanes and an occupancy flag derived from the registered valids.
module bundle_slot
  import issue_pipe_buf_pkg::*;
#(
  parameter int LANES  = ISSUE_LANES,
  parameter int TAG_W  = ISSUE_TAG_W,
  parameter int DATA_W = ISSUE_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_kill_en,
  input  logic [TAG_W-1:0]               i_kill_tag,
  input  logic                           i_ld,
  input  logic                           i_clr,
  input  logic [LANES-1:0]               i_valid,
  input  logic [LANES-1:0][TAG_W-1:0]    i_tag,
  input  logic [LANES-1:0][DATA_W-1:0]   i_data,
  output logic [LANES-1:0]               o_valid,
  output logic [LANES-1:0][TAG_W-1:0]    o_tag,
  output logic [LANES-1:0][DATA_W-1:0]   o_data,
  output logic [LANES-1:0]               o_kvalid,
  output logic                           o_occ
);

  logic [LANES-1:0]             r_valid;
  logic [LANES-1:0][TAG_W-1:0]  r_tag;
  logic [LANES-1:0][DATA_W-1:0] r_data;
  logic [LANES-1:0]             w_kill;

  for (genvar g = 0; g < LANES; g++) begin : g_kill
    assign w_kill[g] = i_kill_en & tag_younger(32'(r_tag[g]), 32'(i_kill_tag), TAG_W);
  end

  assign o_kvalid = r_valid & ~w_kill;
  assign o_occ    = |r_valid;
  assign o_valid  = r_valid;
  assign o_tag    = r_tag;
  assign o_data   = r_data;

  // Holding a slot still applies the kill mask, so no explicit keep path is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= '0;
    end else if (i_ld) begin
      r_valid <= i_valid;
      r_tag   <= i_tag;
      r_data  <= i_data;
    end else begin
      r_valid <= o_kvalid;
    end
  end

endmodule

// File: rtl/issue_pipe_buf.sv
// Multi-lane inter-stage buffer: HEAD drives the outputs, SKID absorbs one
// bundle during a stall so in_ready depends on registered state only.
module issue_pipe_buf
  import issue_pipe_buf_pkg::*;
#(
  parameter int LANES  = ISSUE_LANES,
  parameter int DATA_W = ISSUE_DATA_W,
  parameter int TAG_W  = ISSUE_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    kill_en,
  input  logic [TAG_W-1:0]        kill_tag,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*TAG_W-1:0]  in_tag,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*TAG_W-1:0]  out_tag,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    out_ready,
  output logic [1:0]              occupancy
);

  logic [LANES-1:0][TAG_W-1:0]  w_in_tag;
  logic [LANES-1:0][DATA_W-1:0] w_in_data;
  logic [LANES-1:0]             w_in_kvalid;

  logic [LANES-1:0]             w_h_valid, w_h_kvalid, w_s_valid, w_s_kvalid;
  logic [LANES-1:0][TAG_W-1:0]  w_h_tag, w_s_tag;
  logic [LANES-1:0][DATA_W-1:0] w_h_data, w_s_data;
  logic                         w_h_occ, w_s_occ;

  logic [LANES-1:0]             w_h_ld_valid;
  logic [LANES-1:0][TAG_W-1:0]  w_h_ld_tag;
  logic [LANES-1:0][DATA_W-1:0] w_h_ld_data;

  logic w_push, w_pop, w_in_live, w_h_live, w_s_live, w_h_keep;
  logic w_h_ld, w_h_clr, w_s_ld, w_s_clr, w_h_from_skid;

  assign w_in_tag  = in_tag;
  assign w_in_data = in_data;

  for (genvar g = 0; g < LANES; g++) begin : g_in_kill
    assign w_in_kvalid[g] = in_valid[g] &
      ~(kill_en & tag_younger(32'(w_in_tag[g]), 32'(kill_tag), TAG_W));
  end

  assign w_push    = in_ready & (|in_valid);
  assign w_pop     = out_ready & w_h_occ;
  assign w_in_live = w_push & (|w_in_kvalid);
  assign w_h_live  = |w_h_kvalid;
  assign w_s_live  = |w_s_kvalid;
  assign w_h_keep  = w_h_live & ~w_pop;

  // Slots are judged after the kill mask; a killed-empty HEAD is refilled like a popped one
  always_comb begin
    w_h_ld        = 1'b0;
    w_h_clr       = 1'b0;
    w_s_ld        = 1'b0;
    w_s_clr       = 1'b0;
    w_h_from_skid = 1'b0;
    if (flush) begin
      w_h_clr = 1'b1;
      w_s_clr = 1'b1;
    end else if (w_h_keep) begin
      w_s_ld = w_in_live & ~w_s_live;
    end else begin
      w_s_clr = 1'b1;
      if (w_s_live) begin
        w_h_ld        = 1'b1;
        w_h_from_skid = 1'b1;
      end else if (w_in_live) begin
        w_h_ld = 1'b1;
      end else begin
        w_h_clr = 1'b1;
      end
    end
  end

  assign w_h_ld_valid = w_h_from_skid ? w_s_kvalid : w_in_kvalid;
  assign w_h_ld_tag   = w_h_from_skid ? w_s_tag    : w_in_tag;
  assign w_h_ld_data  = w_h_from_skid ? w_s_data   : w_in_data;

  bundle_slot #(.LANES(LANES), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_head (
    .clk        (clk),
    .rst        (rst),
    .i_kill_en  (kill_en),
    .i_kill_tag (kill_tag),
    .i_ld       (w_h_ld),
    .i_clr      (w_h_clr),
    .i_valid    (w_h_ld_valid),
    .i_tag      (w_h_ld_tag),
    .i_data     (w_h_ld_data),
    .o_valid    (w_h_valid),
    .o_tag      (w_h_tag),
    .o_data     (w_h_data),
    .o_kvalid   (w_h_kvalid),
    .o_occ      (w_h_occ)
  );

  bundle_slot #(.LANES(LANES), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_kill_en  (kill_en),
    .i_kill_tag (kill_tag),
    .i_ld       (w_s_ld),
    .i_clr      (w_s_clr),
    .i_valid    (w_in_kvalid),
    .i_tag      (w_in_tag),
    .i_data     (w_in_data),
    .o_valid    (w_s_valid),
    .o_tag      (w_s_tag),
    .o_data     (w_s_data),
    .o_kvalid   (w_s_kvalid),
    .o_occ      (w_s_occ)
  );

  assign in_ready  = ~w_s_occ;
  assign out_valid = w_h_valid;
  assign out_tag   = w_h_tag;
  assign out_data  = w_h_data;
  assign occupancy = {1'b0, w_h_occ} + {1'b0, w_s_occ};

endmodule

// File: tb/tb_issue_pipe_buf.sv
// Directed vector table for the documented scenarios, then randomized traffic
// checked against a queue-of-bundles reference model.
module tb_issue_pipe_buf;

  logic        clk = 1'b0;
  logic        rst, flush, kill_en, out_ready, in_ready;
  logic [2:0]  kill_tag;
  logic [1:0]  in_valid, out_valid, occupancy;
  logic [5:0]  in_tag, out_tag;
  logic [31:0] in_data, out_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  issue_pipe_buf #(.LANES(2), .DATA_W(16), .TAG_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .kill_en   (kill_en),
    .kill_tag  (kill_tag),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  typedef struct {
    logic        r, f, k;
    logic [2:0]  kt;
    logic [1:0]  iv;
    logic [2:0]  t0, t1;
    logic [15:0] d0, d1;
    logic        ordy;
    logic [1:0]  ev, eocc;
    logic        erdy;
    logic [15:0] e0, e1;
  } vec_t;

  typedef struct packed {
    logic [1:0]       v;
    logic [1:0][2:0]  t;
    logic [1:0][15:0] d;
  } bund_t;

  vec_t  tbl[28];
  bund_t q[$];

  function automatic vec_t mk(input logic r, f, k, input logic [2:0] kt, input logic [1:0] iv,
                              input logic [2:0] t0, t1, input logic [15:0] d0, d1,
                              input logic ordy, input logic [1:0] ev, eocc, input logic erdy,
                              input logic [15:0] e0, e1);
    vec_t v;
    v.r = r; v.f = f; v.k = k; v.kt = kt; v.iv = iv; v.t0 = t0; v.t1 = t1;
    v.d0 = d0; v.d1 = d1; v.ordy = ordy; v.ev = ev; v.eocc = eocc; v.erdy = erdy;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  function automatic logic [31:0] mask_d(input logic [1:0] v, input logic [31:0] d);
    return {v[1] ? d[31:16] : 16'h0, v[0] ? d[15:0] : 16'h0};
  endfunction

  function automatic logic [5:0] mask_t(input logic [1:0] v, input logic [5:0] t);
    return {v[1] ? t[5:3] : 3'h0, v[0] ? t[2:0] : 3'h0};
  endfunction

  function automatic bit younger(input logic [2:0] t, input logic [2:0] k);
    int d;
    d = (int'(t) - int'(k) + 8) % 8;
    return (d >= 1) && (d <= 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, f, k, input logic [2:0] kt, input logic [1:0] iv,
                       input logic [5:0] t, input logic [31:0] d, input logic ordy);
    rst = r; flush = f; kill_en = k; kill_tag = kt;
    in_valid = iv; in_tag = t; in_data = d; out_ready = ordy;
  endtask

  // Reference: up to two bundles in order; kill drops younger lanes and then empty bundles
  task automatic model_step();
    bit    pop, push;
    bund_t nb, b;
    bund_t tmp[$];
    pop  = out_ready && (q.size() > 0);
    push = (q.size() < 2) && (in_valid != 2'b00);
    if (rst || flush) begin
      q.delete();
      return;
    end
    if (pop) void'(q.pop_front());
    nb.v = in_valid; nb.t = in_tag; nb.d = in_data;
    if (push) q.push_back(nb);
    if (kill_en) begin
      tmp = {};
      foreach (q[i]) begin
        b = q[i];
        for (int l = 0; l < 2; l++) if (younger(b.t[l], kill_tag)) b.v[l] = 1'b0;
        if (b.v != 2'b00) tmp.push_back(b);
      end
      q = tmp;
    end
  endtask

  task automatic check_model(input int cyc);
    logic [1:0]  ev;
    logic [5:0]  et;
    logic [31:0] ed;
    ev = 2'b00; et = '0; ed = '0;
    if (q.size() > 0) begin
      ev = q[0].v; et = q[0].t; ed = q[0].d;
    end
    chk($sformatf("rnd%0d_out_valid", cyc), 32'(out_valid), 32'(ev));
    chk($sformatf("rnd%0d_occupancy", cyc), 32'(occupancy), 32'(q.size()));
    chk($sformatf("rnd%0d_in_ready", cyc), 32'(in_ready), 32'(q.size() < 2));
    chk($sformatf("rnd%0d_out_tag", cyc), 32'(mask_t(ev, out_tag)), 32'(mask_t(ev, et)));
    chk($sformatf("rnd%0d_out_data", cyc), mask_d(ev, out_data), mask_d(ev, ed));
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 6'd0, 32'd0, 1'b0);

    //            r f k kt iv t0 t1 d0       d1       or ev eocc rdy e0      e1
    tbl[0]  = mk(1,0,0,0, 0, 0, 0, 16'h0,   16'h0,   0, 0, 0, 1, 16'h0,   16'h0);
    tbl[1]  = mk(0,0,0,0, 3, 0, 1, 16'hA,   16'hB,   1, 3, 1, 1, 16'hA,   16'hB);
    tbl[2]  = mk(0,0,0,0, 0, 0, 0, 16'h0,   16'h0,   1, 0, 0, 1, 16'h0,   16'h0);
    tbl[3]  = mk(0,0,0,0, 3, 1, 2, 16'h11,  16'h12,  0, 3, 1, 1, 16'h11,  16'h12);
    tbl[4]  = mk(0,0,0,0, 3, 3, 4, 16'h21,  16'h22,  0, 3, 2, 0, 16'h11,  16'h12);
    tbl[5]  = mk(0,0,0,0, 3, 5, 6, 16'h31,  16'h32,  0, 3, 2, 0, 16'h11,  16'h12);
    tbl[6]  = mk(0,0,0,0, 3, 5, 6, 16'h31,  16'h32,  1, 3, 1, 1, 16'h21,  16'h22);
    tbl[7]  = mk(0,0,0,0, 3, 5, 6, 16'h31,  16'h32,  1, 3, 1, 1, 16'h31,  16'h32);
    tbl[8]  = mk(0,0,0,0, 0, 0, 0, 16'h0,   16'h0,   1, 0, 0, 1, 16'h0,   16'h0);
    tbl[9]  = mk(0,0,0,0, 3, 2, 3, 16'hA2,  16'hA3,  0, 3, 1, 1, 16'hA2,  16'hA3);
    tbl[10] = mk(0,0,0,0, 3, 4, 5, 16'hB4,  16'hB5,  0, 3, 2, 0, 16'hA2,  16'hA3);
    tbl[11] = mk(0,0,1,2, 0, 0, 0, 16'h0,   16'h0,   0, 1, 1, 1, 16'hA2,  16'h0);
    tbl[12] = mk(0,0,0,0, 0, 0, 0, 16'h0,   16'h0,   1, 0, 0, 1, 16'h0,   16'h0);
    tbl[13] = mk(0,0,0,0, 3, 7, 0, 16'hC7,  16'hC0,  0, 3, 1, 1, 16'hC7,  16'hC0);
    tbl[14] = mk(0,0,1,7, 0, 0, 0, 16'h0,   16'h0,   0, 1, 1, 1, 16'hC7,  16'h0);
    tbl[15] = mk(0,0,1,0, 0, 0, 0, 16'h0,   16'h0,   0, 1, 1, 1, 16'hC7,  16'h0);
    tbl[16] = mk(0,0,0,0, 0, 0, 0, 16'h0,   16'h0,   1, 0, 0, 1, 16'h0,   16'h0);
    tbl[17] = mk(0,0,0,0, 3, 1, 2, 16'hD1,  16'hD2,  0, 3, 1, 1, 16'hD1,  16'hD2);
    tbl[18] = mk(0,0,0,0, 3, 3, 4, 16'hE3,  16'hE4,  0, 3, 2, 0, 16'hD1,  16'hD2);
    tbl[19] = mk(0,1,0,0, 3, 5, 6, 16'hF5,  16'hF6,  1, 0, 0, 1, 16'h0,   16'h0);
    tbl[20] = mk(0,0,0,0, 0, 0, 0, 16'h0,   16'h0,   0, 0, 0, 1, 16'h0,   16'h0);
    tbl[21] = mk(0,0,0,0, 0, 0, 0, 16'h0,   16'h0,   0, 0, 0, 1, 16'h0,   16'h0);
    tbl[22] = mk(0,0,1,0, 3, 0, 1, 16'hF0,  16'hF1,  0, 1, 1, 1, 16'hF0,  16'h0);
    tbl[23] = mk(0,0,0,0, 0, 0, 0, 16'h0,   16'h0,   1, 0, 0, 1, 16'h0,   16'h0);
    tbl[24] = mk(0,0,1,0, 3, 1, 2, 16'h91,  16'h92,  0, 0, 0, 1, 16'h0,   16'h0);
    tbl[25] = mk(0,0,0,0, 3, 3, 4, 16'h33,  16'h34,  0, 3, 1, 1, 16'h33,  16'h34);
    tbl[26] = mk(0,0,0,0, 3, 5, 6, 16'h55,  16'h56,  1, 3, 1, 1, 16'h55,  16'h56);
    tbl[27] = mk(0,0,0,0, 0, 0, 0, 16'h0,   16'h0,   1, 0, 0, 1, 16'h0,   16'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].k, tbl[i].kt, tbl[i].iv, {tbl[i].t1, tbl[i].t0},
            {tbl[i].d1, tbl[i].d0}, tbl[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].eocc));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
      chk($sformatf("vec%0d_out_data", i), mask_d(tbl[i].ev, out_data),
          mask_d(tbl[i].ev, {tbl[i].e1, tbl[i].e0}));
    end

    // Reset mid-stall with two bundles held and an active pop/push offered
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'b11, {3'd2, 3'd1}, 32'h0102_0101, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'b11, {3'd4, 3'd3}, 32'h0304_0303, 1'b0);
    @(posedge clk); #1;
    chk("stall_occupancy", 32'(occupancy), 32'd2);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 2'b11, {3'd6, 3'd5}, 32'h0506_0505, 1'b1);
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    q.delete();
    for (int c = 0; c < 3000; c++) begin
      drive(c == 0 || $urandom_range(0, 299) == 0,
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 5) == 0,
            3'($urandom),
            2'($urandom),
            6'($urandom),
            $urandom,
            $urandom_range(0, 9) < 6);
      @(posedge clk);
      model_step();
      #1;
      check_model(c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_pipe_buf.md
# issue_pipe_buf

Parametrised inter-stage pipeline buffer for the multi-issue core, the successor to the fixed two-lane DE→EX and EX→WB registers with `rst`/`stop`. It carries a bundle of `LANES` instructions, each with a valid bit, an order tag and an opaque payload. It uses a valid/ready handshake with a two-entry skid, so stalls never need a combinational ready path. It also supports global flush and tag-based kill of younger instructions on branch resolution.

## Interface
Parameters:
- `LANES`, 2: issue lanes per bundle.
- `DATA_W`, 160: payload bits per lane (pc, npc, decode_out, operands).
- `TAG_W`, 3: order-tag width; tags compare modulo 2^TAG_W.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard every held and incoming instruction.
- `kill_en`  in  1  branch-resolution kill request.
- `kill_tag`  in  TAG_W  tag of the resolving branch; strictly younger instructions are killed.
- `in_valid`  in  LANES  per-lane valid of the offered bundle.
- `in_tag`  in  LANES*TAG_W  per-lane tag, lane i at [i*TAG_W +: TAG_W].
- `in_data`  in  LANES*DATA_W  per-lane payload.
- `in_ready`  out  1  buffer accepts a bundle this cycle.
- `out_valid`  out  LANES  per-lane valid of the head bundle.
- `out_tag`  out  LANES*TAG_W  head-bundle tags.
- `out_data`  out  LANES*DATA_W  head-bundle payload.
- `out_ready`  in  1  consumer takes the head bundle.
- `occupancy`  out  2  bundles held: 0, 1 or 2.

## Operation
- Storage is two bundle slots: HEAD (drives the outputs) and SKID. Each slot holds a lane-valid vector, tags and data. A slot is occupied iff any lane-valid bit is 1.
- `in_ready = ~skid_occupied`, driven from registered state only.
- Push: `in_ready & |in_valid`. An all-invalid offered bundle is a bubble and is never stored.
- Pop: `out_ready & |out_valid`. `out_*` come directly from HEAD registers.
- Younger test: `d = (t - kill_tag) mod 2^TAG_W`. The instruction is younger iff `1 <= d <= 2^(TAG_W-1) - 1`. Equal tags are never killed.
- Kill, when `kill_en` is high: clear the lane-valid bit of every younger lane in HEAD, in SKID and in the bundle being pushed, before storing. A slot left all-invalid becomes empty. If HEAD empties and SKID does not, SKID moves to HEAD in the same update.
- Priority within a cycle: `rst` > `flush` > kill > push/pop.
- Flush: both slots empty next cycle, incoming bundle dropped, pop ignored.
- Next-state rules, with kill applied first:
  - HEAD empty: a push goes to HEAD.
  - HEAD full and popped: SKID moves to HEAD if occupied, otherwise the push goes to HEAD.
  - HEAD full, not popped: the push goes to SKID. This is only possible when SKID is empty.
  - SKID is never occupied while HEAD is empty.
- Order is preserved; lane positions within a bundle never change.

## Timing
- Reset values: all valid bits 0, `out_valid` 0, `out_tag` 0, `out_data` 0, `occupancy` 0, `in_ready` 1.
- Latency from push into an empty buffer to `out_valid`: 1 cycle. Sustained throughput: 1 bundle/cycle with `out_ready` held high.
- `out_ready` low for 1 cycle with continuous pushes: SKID fills and `in_ready` drops the next cycle. The next pop restores `in_ready` one cycle later.
- A push and a pop in the same cycle with SKID empty leaves occupancy unchanged.
- Kill and flush take effect on state at the next edge. Same-cycle outputs are unaffected, so the consumer must itself gate an instruction being killed that cycle.
- A reset asserted mid-stall clears everything at the next edge, regardless of `out_ready`.

## Structure
- Shared header `def.vh` holds `ISSUE_LANES`, `ISSUE_TAG_W`, the default payload width and the tag-younger macro/function. The same comparison is reused by the LAUNCH_SELECT and WB ordering logic.
- One sub-module, `bundle_slot`: holds one slot's lane valids, tags and data, applies the kill mask, and reports occupancy. It is instantiated twice, for HEAD and SKID.

## Test plan
- Reset, then push `in_valid=2'b11` with tags 0/1 and data 0xA/0xB while `out_ready=1`. Expect `out_valid=2'b11` and `out_data` A/B one cycle later, and `occupancy=1`.
- Hold `out_ready=0` and push 3 consecutive bundles. Expect bundle 1 in HEAD, bundle 2 in SKID, `in_ready=0` from cycle 3, and the third bundle held off by the producer. Then release and check output order 1, 2, 3.
- HEAD holds tags 2/3 and SKID holds tags 4/5; pulse `kill_en` with `kill_tag=2`. Expect `out_valid=2'b01` (tag 2 survives), SKID emptied, `occupancy=1`.
- Wrap-around: HEAD holds tags 7/0 and `kill_tag=7`. Tag 0 is killed (d=1) and tag 7 is kept. With `kill_tag=0`, tag 7 is not killed (d=7).
- Assert `flush` in the same cycle as a push and a pop, with both slots full. Next cycle: `out_valid=0`, `occupancy=0`, `in_ready=1`.
- Push the bubble `in_valid=2'b00` repeatedly. Occupancy stays 0; then assert `rst` mid-stall with 2 bundles held and check all reset values the next cycle.
